aftab_regfile_dbg_arbiter: RTL

- Arbitrates the AFTAB register-file ports between the core datapath and the debug module.
- Default: core signals pass straight through to the register file.
- A debug read or write of a GPR is sequenced by an FSM. The FSM waits, with a timeout, for the core to be halted, takes the ports for one cycle, then returns a one-cycle acknowledge.
- Sits between the datapath control and the register file. Only the arbiter drives the register file's write and read-select inputs.

---
 rtl/aftab_dbg_pkg.sv | 19 +
 rtl/aftab_regfile_dbg_arbiter_if.sv | 27 ++
 rtl/aftab_regfile_port_mux.sv | 53 +++++
 rtl/aftab_regfile_dbg_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/aftab_dbg_pkg.sv
// Shared definitions for the AFTAB register-file debug arbiter: sequencer
// state encoding, GPR address width and a small address helper.
package aftab_dbg_pkg;

  localparam int GPR_AW = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HALT = 2'd1,
    ACCESS    = 2'd2,
    RESP      = 2'd3
  } dbg_state_e;

  // x0 is hardwired to zero in the ISA; debug accesses to it are special-cased.
  function automatic logic is_x0(input logic [GPR_AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/aftab_regfile_dbg_arbiter_if.sv
// Debug-module side handshake of the register-file arbiter.
// master = debug module (requester), slave = arbiter.
interface aftab_regfile_dbg_arbiter_if #(
  parameter int size = 32
);
  import aftab_dbg_pkg::*;

  logic              dbgReq;
  logic              dbgWrite;
  logic [GPR_AW-1:0] dbgAddr;
  logic [size-1:0]   dbgWData;
  logic              dbgAck;
  logic              dbgErr;
  logic [size-1:0]   dbgRData;
  logic              dbgBusy;

  modport master (
    output dbgReq, dbgWrite, dbgAddr, dbgWData,
    input  dbgAck, dbgErr, dbgRData, dbgBusy
  );

  modport slave (
    input  dbgReq, dbgWrite, dbgAddr, dbgWData,
    output dbgAck, dbgErr, dbgRData, dbgBusy
  );

endinterface

// File: rtl/aftab_regfile_port_mux.sv
// Combinational core/debug selector in front of the register-file ports.
// Outside the debug access cycle the core controls pass through untouched so
// core traffic sees no added latency.
module aftab_regfile_port_mux
  import aftab_dbg_pkg::*;
#(
  parameter int size = 32
) (
  input  logic              access,
  input  logic              dbg_write,
  input  logic              dbg_wr_en,
  input  logic [GPR_AW-1:0] dbg_addr,
  input  logic [size-1:0]   dbg_wdata,

  input  logic [GPR_AW-1:0] coreRs1,
  input  logic [GPR_AW-1:0] coreRs2,
  input  logic [GPR_AW-1:0] coreRd,
  input  logic [size-1:0]   coreWriteData,
  input  logic              coreWriteRegFile,
  input  logic              coreSetZero,
  input  logic              coreSetOne,

  output logic [GPR_AW-1:0] rfRs1,
  output logic [GPR_AW-1:0] rfRs2,
  output logic [GPR_AW-1:0] rfRd,
  output logic [size-1:0]   rfWriteData,
  output logic              rfWriteRegFile,
  output logic              rfSetZero,
  output logic              rfSetOne
);

  // Pass-through by default; in the access cycle debug owns Rs1 (read) or
  // Rd/write data (write). dbg_wr_en already folds in halt, reset and x0.
  always_comb begin
    rfRs1          = coreRs1;
    rfRs2          = coreRs2;
    rfRd           = coreRd;
    rfWriteData    = coreWriteData;
    rfWriteRegFile = coreWriteRegFile;
    rfSetZero      = coreSetZero;
    rfSetOne       = coreSetOne;
    if (access) begin
      rfRs1          = dbg_write ? '0 : dbg_addr;
      rfRs2          = coreRs2;
      rfRd           = dbg_write ? dbg_addr : '0;
      rfWriteData    = dbg_write ? dbg_wdata : '0;
      rfWriteRegFile = dbg_write & dbg_wr_en;
      rfSetZero      = 1'b0;
      rfSetOne       = 1'b0;
    end
  end

endmodule

// File: rtl/aftab_regfile_dbg_arbiter.sv
// AFTAB register-file arbiter between the core datapath and the debug module.
// A debug GPR read/write waits (bounded) for the core to halt, owns the
// register-file ports for one cycle, then returns a one-cycle acknowledge.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | core passes through; a debug request is latched here
// WAIT_HALT | waiting for coreHalted, up to TIMEOUT cycles
// ACCESS    | debug drives the register-file ports for exactly one cycle
// RESP      | dbgAck high for one cycle, dbgErr reports timeout/abort
module aftab_regfile_dbg_arbiter
  import aftab_dbg_pkg::*;
#(
  parameter int size    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [GPR_AW-1:0] coreRs1,
  input  logic [GPR_AW-1:0] coreRs2,
  input  logic [GPR_AW-1:0] coreRd,
  input  logic [size-1:0]   coreWriteData,
  input  logic              coreWriteRegFile,
  input  logic              coreSetZero,
  input  logic              coreSetOne,
  input  logic              coreHalted,

  aftab_regfile_dbg_arbiter_if.slave dbg,

  output logic [GPR_AW-1:0] rfRs1,
  output logic [GPR_AW-1:0] rfRs2,
  output logic [GPR_AW-1:0] rfRd,
  output logic [size-1:0]   rfWriteData,
  output logic              rfWriteRegFile,
  output logic              rfSetZero,
  output logic              rfSetOne,
  input  logic [size-1:0]   rfP1
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  dbg_state_e        state;
  logic [CW-1:0]     cnt;
  logic              lat_write;
  logic [GPR_AW-1:0] lat_addr;
  logic [size-1:0]   lat_wdata;
  logic              ack_q;
  logic              err_q;
  logic [size-1:0]   rdata_q;

  logic              access;
  logic              dbg_wr_en;

  // Sequencer, halt-wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg.dbgReq) begin
            lat_write <= dbg.dbgWrite;
            lat_addr  <= dbg.dbgAddr;
            lat_wdata <= dbg.dbgWData;
            cnt       <= '0;
            state     <= WAIT_HALT;
          end
        end
        WAIT_HALT: begin
          if (coreHalted) begin
            state <= ACCESS;
          end else if (cnt == CNT_LAST) begin
            ack_q <= 1'b1;
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACCESS: begin
          // A halt that drops during the access cycle aborts it: no capture.
          if (coreHalted && !lat_write) begin
            rdata_q <= is_x0(lat_addr) ? '0 : rfP1;
          end
          ack_q <= 1'b1;
          err_q <= ~coreHalted;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign access = (state == ACCESS);
  // Write strobe is withheld on abort, on reset (pending access is dropped)
  // and for x0 so a debug write to x0 cannot disturb the register file.
  assign dbg_wr_en = coreHalted & ~rst & ~is_x0(lat_addr);

  assign dbg.dbgAck   = ack_q;
  assign dbg.dbgErr   = err_q;
  assign dbg.dbgRData = rdata_q;
  assign dbg.dbgBusy  = (state != IDLE);

  aftab_regfile_port_mux #(
    .size(size)
  ) u_port_mux (
    .access           (access),
    .dbg_write        (lat_write),
    .dbg_wr_en        (dbg_wr_en),
    .dbg_addr         (lat_addr),
    .dbg_wdata        (lat_wdata),
    .coreRs1          (coreRs1),
    .coreRs2          (coreRs2),
    .coreRd           (coreRd),
    .coreWriteData    (coreWriteData),
    .coreWriteRegFile (coreWriteRegFile),
    .coreSetZero      (coreSetZero),
    .coreSetOne       (coreSetOne),
    .rfRs1            (rfRs1),
    .rfRs2            (rfRs2),
    .rfRd             (rfRd),
    .rfWriteData      (rfWriteData),
    .rfWriteRegFile   (rfWriteRegFile),
    .rfSetZero        (rfSetZero),
    .rfSetOne         (rfSetOne)
  );

endmodule
